ak4619_cfg_seq: RTL and testbench

AK4619_CFG_SEQ -- requirements
Module: ak4619_cfg_seq

---
 rtl/ak4619_cfg_seq.sv | 251 +++++++++++++++++++++++++
 tb/tb_ak4619_cfg_seq.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ak4619_cfg_seq.sv
// AK4619 codec configuration sequencer: powers the codec down and up, then writes
// a (register, value) image over a byte-level I2C master, retrying NACKed
// transactions, and finally enables the audio serial datapath.
module ak4619_cfg_seq #(
  parameter logic [6:0] DEV_ADDR     = 7'h10,
  parameter int         N_REGS       = 21,
  parameter int         PDN_LOW_CYC  = 1200,
  parameter int         PDN_WAIT_CYC = 12000,
  parameter int         MAX_RETRY    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [$clog2(2*N_REGS)-1:0] rom_addr,
  input  logic [7:0]                  rom_data,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic                        cmd_start,
  output logic                        cmd_stop,
  output logic [7:0]                  cmd_data,
  input  logic                        rsp_valid,
  input  logic                        rsp_ack,
  output logic                        pdn,
  output logic                        codec_en,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [7:0]                  err_reg
);

  localparam int RA_W    = $clog2(2*N_REGS);
  localparam int CNT_MAX = (PDN_WAIT_CYC > PDN_LOW_CYC) ? PDN_WAIT_CYC : PDN_LOW_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RT_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] PDN_LOW   = 4'd1;
  localparam logic [3:0] PDN_WAIT  = 4'd2;
  localparam logic [3:0] FETCH     = 4'd3;
  localparam logic [3:0] SEND_DEV  = 4'd4;
  localparam logic [3:0] SEND_REG  = 4'd5;
  localparam logic [3:0] SEND_DATA = 4'd6;
  localparam logic [3:0] WAIT_RSP  = 4'd7;
  localparam logic [3:0] NEXT      = 4'd8;
  localparam logic [3:0] DONE      = 4'd9;
  localparam logic [3:0] ERROR     = 4'd10;

  logic [3:0]       state_q, state_d;
  logic [3:0]       last_send_q, last_send_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RA_W-1:0]  k_q, k_d;
  logic [RA_W-1:0]  rom_addr_q, rom_addr_d;
  logic [RT_W-1:0]  retry_q, retry_d;
  logic [7:0]       reg_byte_q, reg_byte_d;
  logic [7:0]       val_byte_q, val_byte_d;
  logic [7:0]       cmd_data_q, cmd_data_d;
  logic [7:0]       err_reg_q, err_reg_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_start_q, cmd_start_d;
  logic             cmd_stop_q, cmd_stop_d;
  logic             pdn_q, pdn_d;
  logic             codec_en_q, codec_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Next-state and datapath logic; command outputs are derived from the next state
  // so cmd_valid is a pure flop and never sees cmd_ready combinationally.
  always_comb begin
    state_d     = state_q;
    last_send_d = last_send_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    rom_addr_d  = rom_addr_q;
    retry_d     = retry_q;
    reg_byte_d  = reg_byte_q;
    val_byte_d  = val_byte_q;
    err_reg_d   = err_reg_q;
    pdn_d       = pdn_q;
    codec_en_d  = codec_en_q;
    done_d      = done_q;
    err_d       = err_q;
    cmd_valid_d = 1'b0;
    cmd_start_d = cmd_start_q;
    cmd_stop_d  = cmd_stop_q;
    cmd_data_d  = cmd_data_q;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d    = PDN_LOW;
          done_d     = 1'b0;
          err_d      = 1'b0;
          codec_en_d = 1'b0;
          retry_d    = '0;
          cnt_d      = '0;
          pdn_d      = 1'b0;
        end
      end
      PDN_LOW: begin
        if (cnt_q == CNT_W'(PDN_LOW_CYC - 1)) begin
          cnt_d   = '0;
          pdn_d   = 1'b1;
          state_d = PDN_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PDN_WAIT: begin
        if (cnt_q == CNT_W'(PDN_WAIT_CYC - 1)) begin
          cnt_d      = '0;
          k_d        = '0;
          rom_addr_d = '0;
          state_d    = FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FETCH: begin
        // cycle 0: address 2k on the bus; cycle 1: latch reg, 2k+1 on the bus;
        // cycle 2: latch value
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(0)) begin
          rom_addr_d = (k_q << 1) | RA_W'(1);
        end else if (cnt_q == CNT_W'(1)) begin
          reg_byte_d = rom_data;
        end else begin
          val_byte_d = rom_data;
          cnt_d      = '0;
          state_d    = SEND_DEV;
        end
      end
      SEND_DEV, SEND_REG, SEND_DATA: begin
        if (cmd_valid_q && cmd_ready) begin
          last_send_d = state_q;
          state_d     = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          if (rsp_ack) begin
            if (last_send_q == SEND_DEV)      state_d = SEND_REG;
            else if (last_send_q == SEND_REG) state_d = SEND_DATA;
            else                              state_d = NEXT;
          end else if (retry_q < RT_W'(MAX_RETRY)) begin
            retry_d = retry_q + RT_W'(1);
            state_d = SEND_DEV;
          end else begin
            err_reg_d  = reg_byte_q;
            err_d      = 1'b1;
            codec_en_d = 1'b0;
            state_d    = ERROR;
          end
        end
      end
      NEXT: begin
        retry_d = '0;
        if (k_q == RA_W'(N_REGS - 1)) begin
          done_d     = 1'b1;
          codec_en_d = 1'b1;
          state_d    = DONE;
        end else begin
          k_d        = k_q + RA_W'(1);
          rom_addr_d = (k_q + RA_W'(1)) << 1;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      SEND_DEV: begin
        cmd_valid_d = 1'b1;
        cmd_data_d  = {DEV_ADDR, 1'b0};
        cmd_start_d = 1'b1;
        cmd_stop_d  = 1'b0;
      end
      SEND_REG: begin
        cmd_valid_d = 1'b1;
        cmd_data_d  = reg_byte_d;
        cmd_start_d = 1'b0;
        cmd_stop_d  = 1'b0;
      end
      SEND_DATA: begin
        cmd_valid_d = 1'b1;
        cmd_data_d  = val_byte_d;
        cmd_start_d = 1'b0;
        cmd_stop_d  = 1'b1;
      end
      default: cmd_valid_d = 1'b0;
    endcase

    busy_d = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERROR));
  end

  // State register; reset drops everything immediately, even mid-byte, without a STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_send_q <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      rom_addr_q  <= '0;
      retry_q     <= '0;
      reg_byte_q  <= '0;
      val_byte_q  <= '0;
      cmd_data_q  <= '0;
      err_reg_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_start_q <= 1'b0;
      cmd_stop_q  <= 1'b0;
      pdn_q       <= 1'b0;
      codec_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_send_q <= last_send_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      rom_addr_q  <= rom_addr_d;
      retry_q     <= retry_d;
      reg_byte_q  <= reg_byte_d;
      val_byte_q  <= val_byte_d;
      cmd_data_q  <= cmd_data_d;
      err_reg_q   <= err_reg_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_start_q <= cmd_start_d;
      cmd_stop_q  <= cmd_stop_d;
      pdn_q       <= pdn_d;
      codec_en_q  <= codec_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_start = cmd_start_q;
  assign cmd_stop  = cmd_stop_q;
  assign cmd_data  = cmd_data_q;
  assign pdn       = pdn_q;
  assign codec_en  = codec_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_reg   = err_reg_q;

endmodule

// File: tb/tb_ak4619_cfg_seq.sv
// Bench for ak4619_cfg_seq: I2C master/ROM models plus a command scoreboard.
module tb_ak4619_cfg_seq;

  localparam int N_REGS = 2;
  localparam int RA_W   = $clog2(2*N_REGS);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [RA_W-1:0] rom_addr;
  logic [7:0]      rom_data = 8'h00;
  logic            cmd_valid, cmd_start, cmd_stop;
  logic            cmd_ready = 1'b1;
  logic [7:0]      cmd_data;
  logic            rsp_valid = 1'b0;
  logic            rsp_ack = 1'b0;
  logic            pdn, codec_en, busy, done, err;
  logic [7:0]      err_reg;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int nack_mode = 0;
  bit nack_used = 1'b0;
  logic [7:0] image [0:2*N_REGS-1];
  logic [9:0] exp_q [$];

  ak4619_cfg_seq #(.N_REGS(N_REGS)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
    .cmd_stop(cmd_stop), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
    .pdn(pdn), .codec_en(codec_en), .busy(busy), .done(done), .err(err), .err_reg(err_reg)
  );

  always #5 clk = ~clk;

  // ROM model: one cycle of read latency
  initial begin
    logic [RA_W-1:0] a;
    forever begin
      @(negedge clk);
      a = rom_addr;
      @(posedge clk);
      #1 rom_data = image[a];
    end
  end

  // I2C master model: checks each accepted byte against the scoreboard, answers 3 cycles later
  initial begin
    int   cd;
    logic ack;
    logic [9:0] e;
    cd = 0;
    ack = 1'b1;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_ack = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          rsp_valid = 1'b1;
          rsp_ack = ack;
        end
      end
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        hs_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_byte got s=%0b p=%0b d=%h expected no command", cmd_start, cmd_stop, cmd_data);
        end else begin
          e = exp_q.pop_front();
          if ({cmd_start, cmd_stop, cmd_data} !== e) begin
            errors++;
            $display("FAIL cmd_byte got s=%0b p=%0b d=%h expected s=%0b p=%0b d=%h",
                     cmd_start, cmd_stop, cmd_data, e[9], e[8], e[7:0]);
          end
        end
        ack = 1'b1;
        if (nack_mode == 1 && !nack_used && !cmd_start && !cmd_stop) begin
          ack = 1'b0;
          nack_used = 1'b1;
        end
        if (nack_mode == 2 && !cmd_start && !cmd_stop && cmd_data == 8'h05) ack = 1'b0;
        cd = 3;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic s, input logic p, input logic [7:0] d);
    exp_q.push_back({s, p, d});
  endtask

  task automatic push_reg(input logic [7:0] r, input logic [7:0] v);
    push(1'b1, 1'b0, 8'h20);
    push(1'b0, 1'b0, r);
    push(1'b0, 1'b1, v);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done === 1'b1 || err === 1'b1) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30000) begin
      checks++;
      errors++;
      $display("FAIL wait_end timeout done=%0b err=%0b", done, err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pdn, codec_en, busy, done, err, cmd_valid, cmd_start, cmd_stop} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 00000000",
               {pdn, codec_en, busy, done, err, cmd_valid, cmd_start, cmd_stop});
    end
    checks++;
    if ({err_reg, cmd_data, rom_addr} !== '0) begin
      errors++;
      $display("FAIL reset_data got err_reg=%h cmd_data=%h rom_addr=%0d expected 0", err_reg, cmd_data, rom_addr);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (pdn !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got pdn=%0b busy=%0b expected pdn=0 busy=0", pdn, busy);
    end
  endtask

  task automatic test_nominal_power();
    int cyc, low, first_vld, h0;
    bit rose;
    image[0] = 8'h00; image[1] = 8'h37; image[2] = 8'h01; image[3] = 8'hAE;
    nack_mode = 0;
    push_reg(8'h00, 8'h37);
    push_reg(8'h01, 8'hAE);
    h0 = hs_count;
    pulse_start();
    low = 0; rose = 1'b0; first_vld = -1; cyc = 0;
    while (first_vld < 0 && cyc < 20000) begin
      @(negedge clk);
      if (!rose) begin
        if (pdn === 1'b0) low++;
        else rose = 1'b1;
      end
      if (cmd_valid === 1'b1) first_vld = cyc;
      cyc++;
    end
    checks++;
    if (low != 1200) begin
      errors++;
      $display("FAIL pdn_low_cycles got %0d expected 1200", low);
    end
    checks++;
    if (first_vld != 13203) begin
      errors++;
      $display("FAIL first_cmd_valid got %0d expected 13203", first_vld);
    end
    wait_end();
    checks++;
    if ({done, codec_en, err, busy, pdn} !== 5'b11001) begin
      errors++;
      $display("FAIL nominal_end got done/cen/err/busy/pdn=%b expected 11001", {done, codec_en, err, busy, pdn});
    end
    checks++;
    if (hs_count - h0 != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL nominal_bytes got hs=%0d left=%0d expected hs=6 left=0", hs_count - h0, exp_q.size());
    end
  endtask

  task automatic test_retry_backpressure();
    int n, h0;
    bit unstable;
    logic [7:0] d0;
    nack_mode = 1;
    nack_used = 1'b0;
    push(1'b1, 1'b0, 8'h20);
    push(1'b0, 1'b0, 8'h00);
    push_reg(8'h00, 8'h37);
    push_reg(8'h01, 8'hAE);
    h0 = hs_count;
    cmd_ready = 1'b0;
    pulse_start();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_done got done=%0b busy=%0b expected done=0 busy=1", done, busy);
    end
    n = 0;
    while (cmd_valid !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    d0 = cmd_data;
    pulse_start();
    unstable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_data !== d0 || pdn !== 1'b1) unstable = 1'b1;
    end
    checks++;
    if (unstable || d0 !== 8'h20) begin
      errors++;
      $display("FAIL backpressure_hold got unstable=%0b d0=%h expected unstable=0 d0=20", unstable, d0);
    end
    checks++;
    if (hs_count != h0) begin
      errors++;
      $display("FAIL backpressure_no_hs got %0d expected 0", hs_count - h0);
    end
    @(posedge clk); #1 cmd_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (hs_count != h0 + 1 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_handshake got hs=%0d vld=%0b expected hs=1 vld=0", hs_count - h0, cmd_valid);
    end
    wait_end();
    checks++;
    if ({done, err, codec_en} !== 3'b101 || hs_count - h0 != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL retry_end got done/err/cen=%b hs=%0d left=%0d expected 101 hs=8 left=0",
               {done, err, codec_en}, hs_count - h0, exp_q.size());
    end
  endtask

  task automatic test_abort();
    int h0;
    image[2] = 8'h05;
    nack_mode = 2;
    push_reg(8'h00, 8'h37);
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 1'b0, 8'h20);
      push(1'b0, 1'b0, 8'h05);
    end
    h0 = hs_count;
    pulse_start();
    wait_end();
    checks++;
    if ({err, done, codec_en, busy, pdn} !== 5'b10001) begin
      errors++;
      $display("FAIL abort_flags got err/done/cen/busy/pdn=%b expected 10001", {err, done, codec_en, busy, pdn});
    end
    checks++;
    if (err_reg !== 8'h05) begin
      errors++;
      $display("FAIL abort_err_reg got %h expected 05", err_reg);
    end
    checks++;
    if (hs_count - h0 != 11 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_attempts got hs=%0d left=%0d expected hs=11 left=0", hs_count - h0, exp_q.size());
    end
    image[2] = 8'h01;
    nack_mode = 0;
  endtask

  task automatic test_reset_mid_byte();
    int n, h0;
    push_reg(8'h00, 8'h37);
    push_reg(8'h01, 8'hAE);
    h0 = hs_count;
    pulse_start();
    n = 0;
    while (hs_count == h0 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({pdn, cmd_valid, cmd_stop, busy, err} !== 5'b0 || err_reg !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_byte got pdn/vld/stop/busy/err=%b err_reg=%h expected 00000 00",
               {pdn, cmd_valid, cmd_stop, busy, err}, err_reg);
    end
    rst = 1'b0;
    exp_q.delete();
    push_reg(8'h00, 8'h37);
    push_reg(8'h01, 8'hAE);
    h0 = hs_count;
    pulse_start();
    wait_end();
    checks++;
    if ({done, err, codec_en} !== 3'b101 || hs_count - h0 != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rerun_end got done/err/cen=%b hs=%0d left=%0d expected 101 hs=6 left=0",
               {done, err, codec_en}, hs_count - h0, exp_q.size());
    end
  endtask

  initial begin
    image[0] = 8'h00; image[1] = 8'h37; image[2] = 8'h01; image[3] = 8'hAE;
    test_reset();
    test_nominal_power();
    test_retry_backpressure();
    test_abort();
    test_reset_mid_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
